ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//  PS/2 keyboard receiver feeding the keyboard word of the data memory map (address 24576).
//  Samples the PS/2 clock/data lines, deframes 11-bit Set-2 scan frames and tracks make/break/extended prefixes.
//  Translates each key to the computer's 16-bit key code and holds it on kb_out while the key is down; 0 when no key is down.
//  kb_out connects directly to the data memory's kb_in.
// PARAMETERS
//  SYNC_STAGES     2      flops in each ps2_clk/ps2_data synchroniser (>=2)
//  TIMEOUT_CYCLES  50000  clk cycles allowed between ps2_clk falling edges inside a frame
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  reset      in   1   synchronous, active-high reset
//  ps2_clk    in   1   raw PS/2 clock from the device, asynchronous
//  ps2_data   in   1   raw PS/2 data from the device, asynchronous
//  kb_out     out  16  current key code; 0 = no key down
//  key_valid  out  1   1-cycle pulse on every accepted make code, including typematic repeats
//  frame_err  out  1   1-cycle pulse on a parity, stop-bit or timeout error
// BEHAVIOUR
//  Reset: kb_out=0, key_valid=0, frame_err=0, FSM=IDLE, bit count=0, break/ext flags=0, synchroniser flops=1.
//   Reset mid-frame abandons the partial frame and raises no frame_err.
//  Edge detect: the falling edge is synced ps2_clk 1->0 between consecutive clk cycles. Data is sampled in the same cycle from synced ps2_data.
//  FSM, advancing one step per falling edge:
//   IDLE:   data=0 (start bit) -> DATA, count=0. data=1 -> stay in IDLE, no error.
//   DATA:   shift in LSB first. After 8 bits -> PARITY.
//   PARITY: accept when XOR(8 data bits, parity bit)=1 (odd parity). Record pass/fail. -> STOP.
//   STOP:   data must be 1. -> IDLE. Process the byte only if parity passed and stop=1.
//           Otherwise pulse frame_err, discard the byte, clear break/ext.
//  Timeout: in any state except IDLE, a cycle counter is cleared on each falling edge.
//   Counter reaching TIMEOUT_CYCLES -> IDLE, frame_err pulse, clear break/ext.
//  Byte processing, registered in the cycle after the STOP edge:
//   0xF0 -> break=1.  0xE0 -> ext=1.  Any other byte is a key, with code = translate(ext, byte).
//   Key with break=0 and code!=0: kb_out<=code, key_valid pulses. Repeats of the same key pulse again, kb_out unchanged.
//   Key with break=1: if code==kb_out then kb_out<=0; else no change. Never pulses key_valid.
//   code==0 (unmapped): no output change. After any key byte, break and ext clear.
//  Latency: kb_out/key_valid change 1 clk after the cycle in which the stop-bit falling edge is detected,
//   plus SYNC_STAGES cycles of input sync.
//  Translate, ext=0 (code 0 for anything not listed):
//   letters -> uppercase ASCII 65..90: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M,
//    31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z
//   digits -> 48..57: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9
//   29 space=32, 5A enter=128, 66 backspace=129, 76 esc=140
//  Single key held at a time: a second make overwrites kb_out. A break of the older key is then ignored.
// CONFIGURATION
//  PS2_EXTENDED_EN defined: ext=1 bytes translate as
//   6B left=130, 75 up=131, 74 right=132, 72 down=133, 6C home=134, 69 end=135,
//   7D pgup=136, 7A pgdn=137, 70 insert=138, 71 delete=139. Other ext bytes give 0.
//  PS2_EXTENDED_EN undefined: every ext=1 byte translates to 0.
//   The E0-prefixed key is consumed without any output change.
// TESTING
//  1 reset, send frame 0x1C (parity 0, stop 1) -> key_valid pulses once, kb_out=65; send F0,1C -> kb_out=0, no key_valid
//  2 send 0x5A, then 0x5A again -> kb_out=128, key_valid pulses twice; send F0,1C -> kb_out stays 128
//  3 send 0x1C with parity bit 1 -> frame_err pulses, kb_out unchanged; next valid 0x16 -> kb_out=49
//  4 send start+3 data bits, hold ps2_clk high > TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next 0x29 -> kb_out=32
//  5 send E0,6B -> kb_out=130 with PS2_EXTENDED_EN, unchanged without; send E0,F0,6B -> kb_out=0 (macro on)
//  6 assert reset during DATA after 0x1C made -> kb_out=0, no frame_err; next full 0x1C frame -> kb_out=65

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 Set-2 keyboard receiver: deframes 11-bit scan frames and holds the translated 16-bit key code on kb_out.
// Define PS2_EXTENDED_EN to translate E0-prefixed cursor/navigation keys; otherwise they produce no output.
module ps2_keyboard_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kb_out,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Scan code to key code; 0 means the key has no code.
    function automatic logic [15:0] translate(input logic ext, input logic [7:0] code_byte);
        logic [15:0] code;
        code = 16'd0;
        if (!ext) begin
            case (code_byte)
                8'h1C: code = 16'd65;  8'h32: code = 16'd66;  8'h21: code = 16'd67;
                8'h23: code = 16'd68;  8'h24: code = 16'd69;  8'h2B: code = 16'd70;
                8'h34: code = 16'd71;  8'h33: code = 16'd72;  8'h43: code = 16'd73;
                8'h3B: code = 16'd74;  8'h42: code = 16'd75;  8'h4B: code = 16'd76;
                8'h3A: code = 16'd77;  8'h31: code = 16'd78;  8'h44: code = 16'd79;
                8'h4D: code = 16'd80;  8'h15: code = 16'd81;  8'h2D: code = 16'd82;
                8'h1B: code = 16'd83;  8'h2C: code = 16'd84;  8'h3C: code = 16'd85;
                8'h2A: code = 16'd86;  8'h1D: code = 16'd87;  8'h22: code = 16'd88;
                8'h35: code = 16'd89;  8'h1A: code = 16'd90;
                8'h45: code = 16'd48;  8'h16: code = 16'd49;  8'h1E: code = 16'd50;
                8'h26: code = 16'd51;  8'h25: code = 16'd52;  8'h2E: code = 16'd53;
                8'h36: code = 16'd54;  8'h3D: code = 16'd55;  8'h3E: code = 16'd56;
                8'h46: code = 16'd57;
                8'h29: code = 16'd32;  8'h5A: code = 16'd128; 8'h66: code = 16'd129;
                8'h76: code = 16'd140;
                default: code = 16'd0;
            endcase
        end else begin
`ifdef PS2_EXTENDED_EN
            case (code_byte)
                8'h6B: code = 16'd130; 8'h75: code = 16'd131; 8'h74: code = 16'd132;
                8'h72: code = 16'd133; 8'h6C: code = 16'd134; 8'h69: code = 16'd135;
                8'h7D: code = 16'd136; 8'h7A: code = 16'd137; 8'h70: code = 16'd138;
                8'h71: code = 16'd139;
                default: code = 16'd0;
            endcase
`else
            code = 16'd0;
`endif
        end
        return code;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    state_t         state, state_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shift, shift_n;
    logic           parity_ok, parity_ok_n;
    logic [TW-1:0]  timer, timer_n;
    logic           brk, brk_n;
    logic           ext, ext_n;
    logic [15:0]    kb_out_n;
    logic           key_valid_n;
    logic           frame_err_n;
    logic [15:0]    code;
    logic           timeout;

    // NOTE: synchroniser flops reset to the idle-high line level so release from reset
    // never looks like a falling ps2_clk edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;
    assign code   = translate(ext, shift);
    assign timeout = (state != S_IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
            parity_ok <= 1'b0;
            timer     <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            kb_out    <= 16'd0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            parity_ok <= parity_ok_n;
            timer     <= timer_n;
            brk       <= brk_n;
            ext       <= ext_n;
            kb_out    <= kb_out_n;
            key_valid <= key_valid_n;
            frame_err <= frame_err_n;
        end
    end

    // NOTE: every next-state value is defaulted first so no path leaves a latch behind.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        parity_ok_n = parity_ok;
        brk_n       = brk;
        ext_n       = ext;
        kb_out_n    = kb_out;
        key_valid_n = 1'b0;
        frame_err_n = 1'b0;

        if (state == S_IDLE || fall) timer_n = '0;
        else                         timer_n = timer + TW'(1);

        if (timeout) begin
            state_n     = S_IDLE;
            timer_n     = '0;
            frame_err_n = 1'b1;
            brk_n       = 1'b0;
            ext_n       = 1'b0;
        end else if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!data_s) begin
                        state_n   = S_DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_n   = {data_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = S_PARITY;
                end
                S_PARITY: begin
                    parity_ok_n = ^{shift, data_s};
                    state_n     = S_STOP;
                end
                S_STOP: begin
                    state_n = S_IDLE;
                    if (parity_ok && data_s) begin
                        // The byte is acted on here so outputs update in the following cycle.
                        if (shift == 8'hF0) begin
                            brk_n = 1'b1;
                        end else if (shift == 8'hE0) begin
                            ext_n = 1'b1;
                        end else begin
                            if (!brk && code != 16'd0) begin
                                kb_out_n    = code;
                                key_valid_n = 1'b1;
                            end else if (brk && code == kb_out) begin
                                kb_out_n = 16'd0;
                            end
                            brk_n = 1'b0;
                            ext_n = 1'b0;
                        end
                    end else begin
                        frame_err_n = 1'b1;
                        brk_n       = 1'b0;
                        ext_n       = 1'b0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed scenarios plus random scan-code traffic
// compared against a table-driven keyboard model.
module tb_ps2_keyboard_rx;

    localparam int SYNC = 2;
    localparam int TMO  = 120;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] kb_out;
    logic        key_valid;
    logic        frame_err;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kb_out    (kb_out),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    int total = 0;
    int bad   = 0;
    int kv_cnt = 0, fe_cnt = 0, kv_exp = 0, fe_exp = 0;

    logic [15:0] m_kb;
    bit          m_brk, m_ext;
    logic [15:0] tbl_norm [256];
    logic [15:0] tbl_ext  [256];
    logic [7:0]  norm_keys [40];
    logic [7:0]  ext_keys  [10];
    logic [7:0]  letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0]  digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input bit b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        logic [15:0] code;
        if (!good) begin
            fe_exp++;
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            code = m_ext ? tbl_ext[b] : tbl_norm[b];
            if (!m_brk && code != 0) begin
                m_kb = code;
                kv_exp++;
            end else if (m_brk && code == m_kb) begin
                m_kb = 0;
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(~(^b) ^ bad_par);
        drive_bit(~bad_stop);
        ps2_data = 1'b1;
        cyc(HALF + 4);
        model_byte(b, !(bad_par || bad_stop));
        check($sformatf("kb_out_%02h", b), int'(kb_out), int'(m_kb));
        check($sformatf("key_valid_%02h", b), kv_cnt, kv_exp);
        check($sformatf("frame_err_%02h", b), fe_cnt, fe_exp);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cyc(3);
        reset = 1'b0;
        m_kb  = 0;
        m_brk = 0;
        m_ext = 0;
        cyc(2);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] last_key;
        int         r;

        for (int i = 0; i < 256; i++) begin
            tbl_norm[i] = 0;
            tbl_ext[i]  = 0;
        end
        for (int i = 0; i < 26; i++) begin
            tbl_norm[letters[i]] = 16'(65 + i);
            norm_keys[i] = letters[i];
        end
        for (int i = 0; i < 10; i++) begin
            tbl_norm[digits[i]] = 16'(48 + i);
            norm_keys[26 + i] = digits[i];
        end
        tbl_norm[8'h29] = 32;  norm_keys[36] = 8'h29;
        tbl_norm[8'h5A] = 128; norm_keys[37] = 8'h5A;
        tbl_norm[8'h66] = 129; norm_keys[38] = 8'h66;
        tbl_norm[8'h76] = 140; norm_keys[39] = 8'h76;
        ext_keys = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
`ifdef PS2_EXTENDED_EN
        for (int i = 0; i < 10; i++) tbl_ext[ext_keys[i]] = 16'(130 + i);
`endif

        do_reset();
        check("reset_kb_out", int'(kb_out), 0);
        check("reset_key_valid", int'(key_valid), 0);
        check("reset_frame_err", int'(frame_err), 0);

        // Make and break of A.
        send(8'h1C);
        check("a_make_code", int'(kb_out), 65);
        check("a_make_pulses", kv_cnt, 1);
        send(8'hF0);
        send(8'h1C);
        check("a_break_code", int'(kb_out), 0);
        check("a_break_pulses", kv_cnt, 1);

        // Typematic repeat, then a break of a different key.
        send(8'h5A);
        send(8'h5A);
        check("enter_code", int'(kb_out), 128);
        check("enter_pulses", kv_cnt, 3);
        send(8'hF0);
        send(8'h1C);
        check("other_break_code", int'(kb_out), 128);

        // Parity error, then recovery.
        send(8'h1C, 1'b1, 1'b0);
        check("parity_err_count", fe_cnt, 1);
        check("parity_err_code", int'(kb_out), 128);
        send(8'h16);
        check("digit1_code", int'(kb_out), 49);

        // Stop-bit error.
        send(8'h29, 1'b0, 1'b1);
        check("stop_err_count", fe_cnt, 2);

        // Timeout in the middle of a frame.
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        cyc(TMO + 20);
        fe_exp++;
        m_brk = 0;
        m_ext = 0;
        check("timeout_count", fe_cnt, 3);
        check("timeout_code", int'(kb_out), 49);
        send(8'h29);
        check("space_code", int'(kb_out), 32);

        // Extended keys.
        send(8'hE0);
        send(8'h6B);
`ifdef PS2_EXTENDED_EN
        check("ext_left_code", int'(kb_out), 130);
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
        check("ext_left_break", int'(kb_out), 0);
`else
        check("ext_ignored_code", int'(kb_out), 32);
`endif

        // Reset in the middle of a frame.
        send(8'h1C);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        do_reset();
        check("midframe_reset_code", int'(kb_out), 0);
        cyc(TMO + 20);
        check("midframe_reset_no_err", fe_cnt, fe_exp);
        send(8'h1C);
        check("after_reset_code", int'(kb_out), 65);

        // Random traffic.
        last_key = 8'h1C;
        for (int n = 0; n < 120; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3, 4: b = norm_keys[$urandom_range(0, 39)];
                5:             b = ext_keys[$urandom_range(0, 9)];
                6:             b = 8'hF0;
                7:             b = 8'hE0;
                8:             b = 8'($urandom_range(0, 255));
                default:       b = last_key;
            endcase
            if (b != 8'hF0 && b != 8'hE0) last_key = b;
            if ($urandom_range(0, 11) == 0) send(b, 1'b1, 1'b0);
            else if ($urandom_range(0, 11) == 0) send(b, 1'b0, 1'b1);
            else send(b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
